// File: rtl/pipe_hazard_ctrl.sv
// pipe_hazard_ctrl: pipeline stall/flush/forwarding control with memory-wait tracking (optional HAZARD_PERF_EN perf counters)
module pipe_hazard_ctrl #(
    parameter int MEM_TIMEOUT = 255
) (
    input  logic       clk,
    input  logic       rst,
    input  logic [4:0] rs1_D,
    input  logic [4:0] rs2_D,
    input  logic [4:0] rs1_E,
    input  logic [4:0] rs2_E,
    input  logic [4:0] rd_E,
    input  logic [4:0] rd_M,
    input  logic [4:0] rd_W,
    input  logic       reg_wr_E,
    input  logic       reg_wr_M,
    input  logic       reg_wr_W,
    input  logic [1:0] wb_sel_E,
    input  logic       br_taken_E,
    input  logic [2:0] rd_en_M,
    input  logic [2:0] wr_en_M,
    input  logic       mem_ready,
    output logic       stall_F,
    output logic       stall_D,
    output logic       stall_E,
    output logic       stall_M,
    output logic       clr_D,
    output logic       clr_E,
    output logic       clr_W,
    output logic [1:0] fwd_A,
    output logic [1:0] fwd_B,
`ifdef HAZARD_PERF_EN
    output logic [31:0] stall_cycles,
    output logic [31:0] flush_count,
`endif
    output logic       mem_timeout
);
    typedef enum logic {RUN, MEM_WAIT} state_t;
    localparam logic [7:0] TMAX = 8'(MEM_TIMEOUT);
    localparam logic [7:0] TSET = 8'(MEM_TIMEOUT - 1);
    state_t     state;
    logic [7:0] wait_cnt;
    logic       load_use;
    logic       mem_busy;
    // Hazard detection and priority-resolved stall/flush controls
    always_comb begin
        load_use = wb_sel_E == 2'b10 && reg_wr_E && rd_E != 5'd0 && (rd_E == rs1_D || rd_E == rs2_D);
        mem_busy = (rd_en_M != 3'd0 || wr_en_M != 3'd0) && !mem_ready;
        stall_F  = mem_busy || (!br_taken_E && load_use);
        stall_D  = stall_F;
        stall_E  = mem_busy;
        stall_M  = mem_busy;
        clr_D    = !mem_busy && br_taken_E;
        clr_E    = !mem_busy && (br_taken_E || load_use);
        clr_W    = mem_busy;
    end
    // Operand forwarding, Memory stage has priority over Writeback
    always_comb begin
        fwd_A = (reg_wr_M && rd_M != 5'd0 && rd_M == rs1_E) ? 2'b01 :
                (reg_wr_W && rd_W != 5'd0 && rd_W == rs1_E) ? 2'b10 : 2'b00;
        fwd_B = (reg_wr_M && rd_M != 5'd0 && rd_M == rs2_E) ? 2'b01 :
                (reg_wr_W && rd_W != 5'd0 && rd_W == rs2_E) ? 2'b10 : 2'b00;
    end
    // Memory-wait FSM, saturating wait counter and sticky timeout flag
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state       <= RUN;
            wait_cnt    <= 8'd0;
            mem_timeout <= 1'b0;
        end else begin
            state       <= mem_busy ? MEM_WAIT : RUN;
            wait_cnt    <= (state == RUN || !mem_busy) ? 8'd0 :
                           (wait_cnt == TMAX) ? wait_cnt : wait_cnt + 8'd1;
            mem_timeout <= mem_timeout || (mem_busy && wait_cnt == TSET);
        end
    end
`ifdef HAZARD_PERF_EN
    // Performance counters, wrapping modulo 2^32
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            stall_cycles <= 32'd0;
            flush_count  <= 32'd0;
        end else begin
            stall_cycles <= stall_cycles + {31'd0, stall_F | stall_D | stall_E | stall_M};
            flush_count  <= flush_count + {31'd0, clr_D & clr_E};
        end
    end
`endif
endmodule
